pulse_to_press: RTL and testbench

PULSE_TO_PRESS -- requirements
Module: pulse_to_press

---
 rtl/pulse_to_press.sv | 141 ++++++++++++++
 tb/tb_pulse_to_press.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_to_press.sv
// pulse_to_press: turns one-cycle strobes into button-like presses
// (HOLD cycles high, then GAP cycles low), queueing up to DEPTH
// pulses that arrive while a press is still in progress.
// Ports: clk, reset (sync, active-high), in (strobe),
//   out (registered press level), busy (press active or queued),
//   overflow (sticky drop flag, only with PULSE_TO_PRESS_OVF_EN).
module pulse_to_press #(
  parameter int HOLD  = 4,
  parameter int GAP   = 2,
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic busy
`ifdef PULSE_TO_PRESS_OVF_EN
  ,
  output logic overflow
`endif
);

  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int PW   = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] C_ZERO  = '0;
  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_HLAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] C_GLAST = CW'(GAP - 1);

  localparam logic [PW-1:0] P_ZERO = '0;
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [PW-1:0] P_MAX  = PW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pend;
  logic          r_out;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] w_pend_nxt;
  logic          w_out_nxt;
  logic          w_hold_last;
  logic          w_gap_last;
  logic          w_pend_any;
  logic          w_pend_full;

  assign w_hold_last = (r_state == S_HOLD) && (r_cnt == C_HLAST);
  assign w_gap_last  = (r_state == S_GAP) && (r_cnt == C_GLAST);
  assign w_pend_any  = (r_pend != P_ZERO);
  assign w_pend_full = (r_pend == P_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= C_ZERO;
      r_pend  <= P_ZERO;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pend  <= w_pend_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + C_ONE;
    w_pend_nxt  = r_pend;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = C_ZERO;
        if (in) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_hold_last) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = C_ZERO;
        end
        if (in && !w_pend_full) w_pend_nxt = r_pend + P_ONE;
      end
      S_GAP: begin
        if (w_gap_last) begin
          w_cnt_nxt = C_ZERO;
          // A new pulse here either is taken directly (queue empty)
          // or swaps places with the oldest queued one: net zero.
          if (in) begin
            w_state_nxt = S_HOLD;
          end else if (w_pend_any) begin
            w_state_nxt = S_HOLD;
            w_pend_nxt  = r_pend - P_ONE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (in && !w_pend_full) begin
          w_pend_nxt = r_pend + P_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = C_ZERO;
      end
    endcase
  end

  // Output logic
  always_comb begin
    w_out_nxt = (w_state_nxt == S_HOLD);
    busy      = (r_state != S_IDLE) || w_pend_any;
  end

  assign out = r_out;

`ifdef PULSE_TO_PRESS_OVF_EN
  logic r_ovf;
  logic w_drop;

  // Last-GAP pulses are always absorbed, so they never drop.
  assign w_drop = in && (r_state != S_IDLE) && !w_gap_last
                  && w_pend_full;

  always_ff @(posedge clk) begin
    if (reset) r_ovf <= 1'b0;
    else       r_ovf <= r_ovf | w_drop;
  end

  assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_pulse_to_press.sv
// Directed bench for pulse_to_press with default parameters.
// Each run is 40 cycles; outputs are recorded per cycle.
module tb_pulse_to_press;

  logic clk = 1'b0;
  logic rst_s = 1'b1;
  logic in_s = 1'b0;
  logic out_s;
  logic busy_s;
`ifdef PULSE_TO_PRESS_OVF_EN
  logic ovf_s;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [39:0] obs_out;
  logic [39:0] obs_busy;
  logic [39:0] obs_ovf;

  pulse_to_press #(.HOLD(4), .GAP(2), .DEPTH(3)) dut (
    .clk(clk),
    .reset(rst_s),
    .in(in_s),
    .out(out_s),
    .busy(busy_s)
`ifdef PULSE_TO_PRESS_OVF_EN
    ,
    .overflow(ovf_s)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] rng(input int a, input int b);
    logic [39:0] m;
    m = '0;
    for (int i = a; i <= b; i++) m[i] = 1'b1;
    return m;
  endfunction

  // obs[c] holds the outputs during cycle c; in/reset for cycle c
  // are sampled at the posedge that ends cycle c.
  task automatic run_seq(input logic [39:0] ivec,
                         input logic [39:0] rvec);
    for (int c = 0; c < 40; c++) begin
      obs_out[c]  = out_s;
      obs_busy[c] = busy_s;
`ifdef PULSE_TO_PRESS_OVF_EN
      obs_ovf[c]  = ovf_s;
`else
      obs_ovf[c]  = 1'b0;
`endif
      in_s  = ivec[c];
      rst_s = rvec[c];
      tick();
    end
    in_s  = 1'b0;
    rst_s = 1'b0;
  endtask

  function automatic int edges(input logic [39:0] v);
    int e;
    e = 0;
    for (int c = 2; c < 40; c++)
      if (v[c] === 1'b1 && v[c-1] === 1'b0) e++;
    return e;
  endfunction

  task automatic test_reset();
    logic [39:0] z;
    z = '0;
    run_seq(rng(0, 5), rng(0, 5));
    n_chk++;
    if (obs_out[39:1] !== z[39:1]) begin
      n_fail++;
      $display("FAIL reset_out got %h want %h", obs_out, z);
    end
    n_chk++;
    if (obs_busy[39:1] !== z[39:1]) begin
      n_fail++;
      $display("FAIL reset_busy got %h want %h", obs_busy, z);
    end
`ifdef PULSE_TO_PRESS_OVF_EN
    n_chk++;
    if (obs_ovf[39:1] !== z[39:1]) begin
      n_fail++;
      $display("FAIL reset_ovf got %h want %h", obs_ovf, z);
    end
`endif
  endtask

  task automatic test_single();
    logic [39:0] eo, eb;
    eo = rng(11, 14);
    eb = rng(11, 16);
    run_seq(rng(10, 10), rng(0, 2));
    n_chk++;
    if (obs_out[39:1] !== eo[39:1]) begin
      n_fail++;
      $display("FAIL single_out got %h want %h", obs_out, eo);
    end
    n_chk++;
    if (obs_busy[39:1] !== eb[39:1]) begin
      n_fail++;
      $display("FAIL single_busy got %h want %h", obs_busy, eb);
    end
    n_chk++;
    if (obs_busy[17] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle17 got %b want 0", obs_busy[17]);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] eo, eb;
    eo = rng(11, 14) | rng(17, 20) | rng(23, 26);
    eb = rng(11, 28);
    run_seq(rng(10, 12), rng(0, 2));
    n_chk++;
    if (obs_out[39:1] !== eo[39:1]) begin
      n_fail++;
      $display("FAIL b2b_out got %h want %h", obs_out, eo);
    end
    n_chk++;
    if (obs_busy[39:1] !== eb[39:1]) begin
      n_fail++;
      $display("FAIL b2b_busy got %h want %h", obs_busy, eb);
    end
    n_chk++;
    if (edges(obs_out) !== 3) begin
      n_fail++;
      $display("FAIL b2b_presses got %0d want 3", edges(obs_out));
    end
  endtask

  task automatic test_saturate();
    logic [39:0] eo, eb, ev;
    eo = rng(11, 14) | rng(17, 20) | rng(23, 26) | rng(29, 32);
    eb = rng(11, 34);
    ev = rng(15, 39);
    run_seq(rng(10, 14), rng(0, 2));
    n_chk++;
    if (obs_out[39:1] !== eo[39:1]) begin
      n_fail++;
      $display("FAIL sat_out got %h want %h", obs_out, eo);
    end
    n_chk++;
    if (obs_busy[39:1] !== eb[39:1]) begin
      n_fail++;
      $display("FAIL sat_busy got %h want %h", obs_busy, eb);
    end
    n_chk++;
    if (edges(obs_out) !== 4) begin
      n_fail++;
      $display("FAIL sat_presses got %0d want 4", edges(obs_out));
    end
`ifdef PULSE_TO_PRESS_OVF_EN
    n_chk++;
    if (obs_ovf[39:1] !== ev[39:1]) begin
      n_fail++;
      $display("FAIL sat_ovf got %h want %h", obs_ovf, ev);
    end
`else
    ev = '0;
`endif
  endtask

  task automatic test_abort();
    logic [39:0] eo, eb;
    eo = rng(11, 12);
    eb = rng(11, 12);
    run_seq(rng(10, 11), rng(0, 2) | rng(12, 12));
    n_chk++;
    if (obs_out[39:1] !== eo[39:1]) begin
      n_fail++;
      $display("FAIL abort_out got %h want %h", obs_out, eo);
    end
    n_chk++;
    if (obs_busy[39:1] !== eb[39:1]) begin
      n_fail++;
      $display("FAIL abort_busy got %h want %h", obs_busy, eb);
    end
  endtask

  task automatic test_gap_last();
    logic [39:0] eo, eb;
    eo = rng(11, 14) | rng(17, 20);
    eb = rng(11, 22);
    run_seq(rng(10, 10) | rng(16, 16), rng(0, 2));
    n_chk++;
    if (obs_out[39:1] !== eo[39:1]) begin
      n_fail++;
      $display("FAIL gaplast_out got %h want %h", obs_out, eo);
    end
    n_chk++;
    if (obs_busy[39:1] !== eb[39:1]) begin
      n_fail++;
      $display("FAIL gaplast_busy got %h want %h", obs_busy, eb);
    end
  endtask

  task automatic test_gap_last_pending();
    logic [39:0] eo, eb;
    eo = rng(11, 14) | rng(17, 20) | rng(23, 26);
    eb = rng(11, 28);
    run_seq(rng(10, 11) | rng(16, 16), rng(0, 2));
    n_chk++;
    if (obs_out[39:1] !== eo[39:1]) begin
      n_fail++;
      $display("FAIL gappend_out got %h want %h", obs_out, eo);
    end
    n_chk++;
    if (obs_busy[39:1] !== eb[39:1]) begin
      n_fail++;
      $display("FAIL gappend_busy got %h want %h", obs_busy, eb);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_abort();
    test_gap_last();
    test_gap_last_pending();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
